// File: rtl/spi_arbiter.sv
// spi_arbiter
// Round-robin arbiter and transaction sequencer for a shared 12-bit SPI master.
// It grants the master to one client at a time and latches that client's frame.
// It drives the master's newd/din handshake and watches cs for frame start and end.
// On completion it returns a one-cycle done pulse to the granted client.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a transaction that spends
// TIMEOUT_CYC cycles in ISSUE+BUSY (done and err pulse together). Without the macro,
// err is tied low and the arbiter waits on cs indefinitely.
//
// Parameters:
//   NREQ        - number of requesters (2..8)
//   TIMEOUT_CYC - ISSUE+BUSY cycle budget (timeout build only, must be >= 1)
// Ports:
//   clk      - system clock (the SPI master runs on the same clock)
//   rst      - synchronous active-high reset
//   req      - per-client level request, held until that client's done
//   din      - flattened client frames, client i at din[12*i+11:12*i]
//   gnt      - one-hot grant, high from ISSUE through DONE
//   done     - one-cycle completion pulse to the granted client
//   err      - one-cycle timeout pulse, coincident with done
//   busy     - high whenever the sequencer is not idle
//   spi_newd - to master newd
//   spi_din  - to master din, holds the captured frame
//   spi_cs   - from master cs, active-low frame envelope
module spi_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned TIMEOUT_CYC = 4095
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*12-1:0] din,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic               busy,
    output logic               spi_newd,
    output logic [11:0]        spi_din,
    input  logic               spi_cs
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

    state_e          state_q;
    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] win_q;
    logic            cs_q;

    logic [11:0]     frames [NREQ];
    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;
    logic            tmo_hit;

    // Unflatten the client frame bus.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            frames[i] = din[12*i +: 12];
        end
    end

    // Round-robin pick: scan from last+1 upward (mod NREQ); first requester wins.
    always_comb begin : rr_pick
        int unsigned     idx;
        logic [IdxW-1:0] cand;
        pick_idx   = '0;
        pick_valid = 1'b0;
        idx        = 0;
        cand       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx  = (32'(last_q) + k) % NREQ;
            cand = IdxW'(idx);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 1);

    logic [15:0] tmo_cnt_q;
    logic        err_q;

    // Counter holds the number of completed ISSUE/BUSY cycles, so the abort edge
    // lands exactly TIMEOUT_CYC cycles after ISSUE entry.
    assign tmo_hit = ((state_q == StIssue) || (state_q == StBusy)) && (tmo_cnt_q == TmoLast);
    assign err     = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            last_q   <= IdxW'(NREQ - 1);
            win_q    <= '0;
            cs_q     <= 1'b1;
            gnt      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            spi_newd <= 1'b0;
            spi_din  <= 12'h000;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            // cs comes from a clk-derived master, so a single flop is enough.
            cs_q <= spi_cs;
            done <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err_q <= 1'b0;
            if ((state_q == StIssue) || (state_q == StBusy)) begin
                if (tmo_hit) begin
                    state_q  <= StDone;
                    done     <= gnt;
                    err_q    <= 1'b1;
                    spi_newd <= 1'b0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                end
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q  <= StIssue;
                        win_q    <= pick_idx;
                        gnt      <= NREQ'(1) << pick_idx;
                        spi_din  <= frames[pick_idx];
                        spi_newd <= 1'b1;
                        busy     <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                StIssue: begin
                    // Hold newd until the master has visibly opened the frame.
                    if (!tmo_hit && !cs_q) begin
                        state_q  <= StBusy;
                        spi_newd <= 1'b0;
                    end
                end
                StBusy: begin
                    if (!tmo_hit && cs_q) begin
                        state_q <= StDone;
                        done    <= gnt;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    last_q  <= win_q;
                    gnt     <= '0;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: directed tests with a queue-based scoreboard.
// A behavioural SPI master consumes newd/din and drives cs, recording the bits it
// shifted LSB first. The monitor pops one expected transaction per done pulse.
module tb_spi_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TMO  = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req;
    logic [NREQ*12-1:0] din = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              busy;
    logic              spi_newd;
    logic [11:0]       spi_din;
    logic              spi_cs;

    spi_arbiter #(
        .NREQ       (NREQ),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .done    (done),
        .err     (err),
        .busy    (busy),
        .spi_newd(spi_newd),
        .spi_din (spi_din),
        .spi_cs  (spi_cs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [11:0] frame;
        bit          err;
        bit          chk_frame;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int remaining [NREQ];
    bit cs_hold = 1'b0;
    logic [11:0] rx_word = '0;
    int cs_rise_cyc = 0;
    int gnt_rise_cyc = 0;
    bit gap_check = 1'b0;
    int grants_seen = 0;

    always_comb begin
        for (int i = 0; i < NREQ; i++) req[i] = (remaining[i] != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int idx, input logic [11:0] f, input bit e, input bit cf);
        exp_t x;
        x.idx = idx;
        x.frame = f;
        x.err = e;
        x.chk_frame = cf;
        sb.push_back(x);
    endtask

    task automatic set_frame(input int idx, input logic [11:0] f);
        din[12*idx +: 12] = f;
    endtask

    // Behavioural master: opens the frame 3 cycles after seeing newd, shifts 12 bits
    // LSB first (2 clk per bit), closes cs and idles briefly.
    initial begin : spi_master
        logic [11:0] sh;
        sh = '0;
        spi_cs = 1'b1;
        forever begin
            @(negedge clk);
            if (spi_newd && !cs_hold) begin
                repeat (3) @(negedge clk);
                spi_cs = 1'b0;
                for (int b = 0; b < 12; b++) begin
                    @(negedge clk);
                    sh[b] = spi_din[b];
                    @(negedge clk);
                end
                rx_word = sh;
                spi_cs = 1'b1;
                cs_rise_cyc = cyc;
                repeat (2) @(negedge clk);
            end
        end
    end

    initial begin : monitor
        logic [NREQ-1:0] prev_gnt;
        logic [NREQ-1:0] prev_done;
        int zero_run;
        exp_t e;
        prev_gnt = '0;
        prev_done = '0;
        zero_run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gnt != '0 && prev_gnt == '0) begin
                gnt_rise_cyc = cyc;
                if (gap_check && grants_seen > 0) chk("idle_gap", zero_run, 1);
                grants_seen++;
            end
            if (gnt == '0) zero_run++;
            else zero_run = 0;
            if (err && done == '0) begin
                checks++;
                errors++;
                $display("FAIL err_without_done: err=1 done=0x%0h (cycle %0d)", done, cyc);
            end
            if (done != '0) begin
                chk("done_single_pulse", prev_done, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=0x%0h, expected none", done);
                end else begin
                    e = sb.pop_front();
                    chk("done_onehot", done, 32'(1) << e.idx);
                    chk("gnt_at_done", gnt, 32'(1) << e.idx);
                    chk("err_at_done", err, e.err);
                    if (e.chk_frame) begin
                        chk("mosi_frame", rx_word, e.frame);
                        chk("done_latency", cyc - cs_rise_cyc, 2);
                    end else begin
                        chk("timeout_latency", cyc - gnt_rise_cyc, TMO);
                    end
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (done[i] && remaining[i] > 0) remaining[i]--;
                end
            end
            prev_gnt = gnt;
            prev_done = done;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gap_check = 1'b0;
        grants_seen = 0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        bit pend;
        n = 0;
        forever begin
            @(negedge clk);
            pend = 1'b0;
            for (int i = 0; i < NREQ; i++) if (remaining[i] != 0) pend = 1'b1;
            if (sb.size() == 0 && !busy && !pend) break;
            n++;
            if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL %s: timed out after %0d cycles, %0d transactions outstanding",
                         name, n, sb.size());
                sb.delete();
                for (int i = 0; i < NREQ; i++) remaining[i] = 0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_cs(input string name, input logic lvl, input int budget);
        int n;
        n = 0;
        while (spi_cs !== lvl) begin
            @(negedge clk);
            n++;
            if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL %s: cs never reached %0d, expected within %0d cycles",
                         name, lvl, budget);
                break;
            end
        end
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion by 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit stuck_ok;
        for (int i = 0; i < NREQ; i++) remaining[i] = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_newd", spi_newd, 0);
        chk("rst_spi_din", spi_din, 12'h000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single request, grant one cycle later
        set_frame(0, 12'hA5C);
        push_exp(0, 12'hA5C, 1'b0, 1'b1);
        remaining[0] = 1;
        @(negedge clk);
        chk("single_gnt", gnt, 4'b0001);
        chk("single_spi_din", spi_din, 12'hA5C);
        chk("single_busy", busy, 1);
        chk("single_newd", spi_newd, 1);
        wait_drain("single", 200);

        // All request: order 0,1,2,3,0 with one idle cycle between grants
        do_reset();
        set_frame(0, 12'h111);
        set_frame(1, 12'h222);
        set_frame(2, 12'h333);
        set_frame(3, 12'h444);
        push_exp(0, 12'h111, 1'b0, 1'b1);
        push_exp(1, 12'h222, 1'b0, 1'b1);
        push_exp(2, 12'h333, 1'b0, 1'b1);
        push_exp(3, 12'h444, 1'b0, 1'b1);
        push_exp(0, 12'h111, 1'b0, 1'b1);
        gap_check = 1'b1;
        remaining[0] = 2;
        remaining[1] = 1;
        remaining[2] = 1;
        remaining[3] = 1;
        wait_drain("all_request", 1000);
        gap_check = 1'b0;

        // Fairness: 0 and 2 held -> 0,2,0,2
        do_reset();
        set_frame(0, 12'h0F0);
        set_frame(2, 12'hF0F);
        push_exp(0, 12'h0F0, 1'b0, 1'b1);
        push_exp(2, 12'hF0F, 1'b0, 1'b1);
        push_exp(0, 12'h0F0, 1'b0, 1'b1);
        push_exp(2, 12'hF0F, 1'b0, 1'b1);
        remaining[0] = 2;
        remaining[2] = 2;
        wait_drain("fairness", 1000);

        // Mid-frame change: client 1 drops req and alters its frame in BUSY
        set_frame(1, 12'h3C7);
        push_exp(1, 12'h3C7, 1'b0, 1'b1);
        remaining[1] = 1;
        wait_cs("midframe_cs_low", 1'b0, 50);
        @(negedge clk);
        set_frame(1, 12'hFFF);
        remaining[1] = 0;
        repeat (3) @(negedge clk);
        chk("midframe_spi_din", spi_din, 12'h3C7);
        chk("midframe_gnt", gnt, 4'b0010);
        wait_drain("midframe", 200);

        // Reset in BUSY: no done for the aborted frame, pointer back to NREQ-1
        set_frame(2, 12'h5A5);
        remaining[2] = 1;
        wait_cs("rstbusy_cs_low", 1'b0, 50);
        repeat (4) @(negedge clk);
        remaining[2] = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstbusy_gnt", gnt, 0);
        chk("rstbusy_busy", busy, 0);
        chk("rstbusy_newd", spi_newd, 0);
        chk("rstbusy_spi_din", spi_din, 12'h000);
        rst = 1'b0;
        wait_cs("rstbusy_cs_high", 1'b1, 100);
        repeat (4) @(negedge clk);
        set_frame(0, 12'h00A);
        set_frame(3, 12'hB00);
        push_exp(0, 12'h00A, 1'b0, 1'b1);
        push_exp(3, 12'hB00, 1'b0, 1'b1);
        remaining[0] = 1;
        remaining[3] = 1;
        wait_drain("post_reset", 500);

        // Timeout behaviour with cs held high
        cs_hold = 1'b1;
        set_frame(1, 12'h6D2);
`ifdef SPI_ARB_TIMEOUT_EN
        push_exp(1, 12'h6D2, 1'b1, 1'b0);
        remaining[1] = 1;
        wait_drain("timeout", TMO + 50);
        chk("timeout_newd_dropped", spi_newd, 0);
        cs_hold = 1'b0;
`else
        remaining[1] = 1;
        repeat (2) @(negedge clk);
        stuck_ok = 1'b1;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (!(spi_newd && busy && gnt == 4'b0010)) stuck_ok = 1'b0;
        end
        chk("no_timeout_stuck_in_issue", stuck_ok, 1);
        push_exp(1, 12'h6D2, 1'b0, 1'b1);
        cs_hold = 1'b0;
        wait_drain("no_timeout_release", 200);
`endif
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
